// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel programmable clock divider with double-buffered divisors
// Defining CLK_DIV_TICK_EN adds the per-channel o_tick period strobe.
module clk_div_prog #(
  parameter int          NCH       = 4,
  parameter int          WIDTH     = 26,
  parameter int unsigned RESET_DIV = 50000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       i_en,
  input  logic [NCH-1:0]       i_mode,
  input  logic [NCH-1:0]       i_load,
  input  logic [NCH*WIDTH-1:0] i_div,
  output logic [NCH-1:0]       o_clk,
  output logic [NCH-1:0]       o_busy
`ifdef CLK_DIV_TICK_EN
  ,
  output logic [NCH-1:0]       o_tick
`endif
);

  localparam logic [WIDTH-1:0] RESET_D = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] last_cnt;
    logic             run;
    logic             wrap;
    logic             apply;

    assign div_in   = i_div[k*WIDTH +: WIDTH];
    assign last_cnt = div_q - ONE;
    assign run      = i_en[k] && (div_q >= TWO);
    assign wrap     = run && (cnt_q == last_cnt);
    // A pending divisor lands only on a period boundary, or at once when the channel is idle.
    assign apply    = busy_q && (wrap || !run);

    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      pend_d = pend_q;
      busy_d = busy_q;
      clk_d  = 1'b0;

      if (!run || wrap) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end

      if (apply) begin
        div_d  = pend_q;
        cnt_d  = '0;
        busy_d = 1'b0;
      end

      // A load on the apply edge refills the buffer after the old value has moved to div_q.
      if (i_load[k]) begin
        pend_d = div_in;
        busy_d = 1'b1;
      end

      if (run) begin
        clk_d = i_mode[k] ? wrap : (cnt_q >= (div_q >> 1));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        div_q  <= RESET_D;
        pend_q <= '0;
        busy_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        pend_q <= pend_d;
        busy_q <= busy_d;
        clk_q  <= clk_d;
      end
    end

    assign o_clk[k]  = clk_q;
    assign o_busy[k] = busy_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= wrap;
      end
    end

    assign o_tick[k] = tick_q;
`endif
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard bench for clk_div_prog
// Checks o_tick as well when CLK_DIV_TICK_EN is defined.
module tb_clk_div_prog;

  localparam int NCH       = 4;
  localparam int WIDTH     = 26;
  localparam int RESET_DIV = 6;

  typedef struct {
    int             at;
    string          tag;
    logic [NCH-1:0] cm, cv, bm, bv, tm, tv;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       en, mode, load;
  logic [NCH*WIDTH-1:0] div;
  logic [NCH-1:0]       o_clk, o_busy;
`ifdef CLK_DIV_TICK_EN
  logic [NCH-1:0]       o_tick;
`endif

  exp_t sb[$];
  int   cyc_n;
  int   n_checks;
  int   n_fail;
  int   gdiv [NCH];

  clk_div_prog #(.NCH(NCH), .WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .i_mode (mode),
    .i_load (load),
    .i_div  (div),
    .o_clk  (o_clk),
    .o_busy (o_busy)
`ifdef CLK_DIV_TICK_EN
    ,
    .o_tick (o_tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].at == cyc_n) begin
      e = sb.pop_front();
      if (e.cm != '0) check({e.tag, "_clk"}, 32'(o_clk & e.cm), 32'(e.cv & e.cm));
      if (e.bm != '0) check({e.tag, "_busy"}, 32'(o_busy & e.bm), 32'(e.bv & e.bm));
`ifdef CLK_DIV_TICK_EN
      if (e.tm != '0) check({e.tag, "_tick"}, 32'(o_tick & e.tm), 32'(e.tv & e.tm));
`endif
    end
  end

  task automatic step(input string tag, input logic [NCH-1:0] cm, cv, bm, bv, tm, tv);
    exp_t e;
    e.at  = cyc_n + 1;
    e.tag = tag;
    e.cm  = cm; e.cv = cv;
    e.bm  = bm; e.bv = bv;
    e.tm  = tm; e.tv = tv;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic stepc(input string tag, input int ch, input bit c, input bit b);
    logic [NCH-1:0] m;
    m = '0;
    m[ch] = 1'b1;
    step(tag, m, c ? m : '0, m, b ? m : '0, '0, '0);
  endtask

  task automatic run_sq(input string tag, input int ch, input int d, input int c0, input int n, input bit b);
    int k;
    for (int i = 0; i < n; i++) begin
      k = (c0 + i) % d;
      stepc(tag, ch, k >= d / 2, b);
    end
  endtask

  task automatic run_pulse(input string tag, input int ch, input int d, input int c0, input int n, input bit b);
    int k;
    for (int i = 0; i < n; i++) begin
      k = (c0 + i) % d;
      stepc(tag, ch, k == d - 1, b);
    end
  endtask

  task automatic set_div(input int ch, input int d);
    div[ch*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] cv, tv, bv;
    int             k;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; en = '0; mode = '0; load = '0; div = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk", 32'(o_clk), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
`ifdef CLK_DIV_TICK_EN
    check("rst_tick", 32'(o_tick), 32'd0);
`endif

    // Reset divisor runs straight away: first rise on edge D/2+1
    rst_n = 1'b1; en = 4'b0001;
    run_sq("A_rst_div", 0, RESET_DIV, 0, 12, 1'b0);

    // Load 10 on an idle channel, then run it
    en = '0;
    stepc("B_dis", 0, 1'b0, 1'b0);
    load = 4'b0010; set_div(1, 10);
    stepc("B_load", 1, 1'b0, 1'b1);
    load = '0;
    stepc("B_apply", 1, 1'b0, 1'b0);
    en = 4'b0010;
    run_sq("B_sq10", 1, 10, 0, 20, 1'b0);

    // Load 5 while running, mode switches, enable drop and restart
    load = 4'b0010; set_div(1, 5);
    stepc("C_load", 1, 1'b0, 1'b1);
    load = '0;
    run_sq("C_hold", 1, 10, 1, 8, 1'b1);
    stepc("C_apply", 1, 1'b1, 1'b0);
    run_sq("C_sq5", 1, 5, 0, 12, 1'b0);
    mode = 4'b0010;
    run_pulse("C_pulse", 1, 5, 2, 13, 1'b0);
    mode = '0;
    run_sq("C_sq_back", 1, 5, 0, 4, 1'b0);
    en = '0;
    stepc("C_dis", 1, 1'b0, 1'b0);
    stepc("C_idle", 1, 1'b0, 1'b0);
    en = 4'b0010;
    run_sq("C_reen", 1, 5, 0, 5, 1'b0);
    en = '0;
    stepc("C_off", 1, 1'b0, 1'b0);

    // D=8 running, load 4 at cnt=3
    load = 4'b0100; set_div(2, 8);
    stepc("D_load8", 2, 1'b0, 1'b1);
    load = '0;
    stepc("D_apply8", 2, 1'b0, 1'b0);
    en = 4'b0100;
    run_sq("D_sq8", 2, 8, 0, 3, 1'b0);
    load = 4'b0100; set_div(2, 4);
    stepc("D_load4", 2, 1'b0, 1'b1);
    load = '0;
    run_sq("D_hold", 2, 8, 4, 3, 1'b1);
    stepc("D_apply4", 2, 1'b1, 1'b0);
    run_sq("D_sq4", 2, 4, 0, 8, 1'b0);

    // Load on the same edge as an apply
    load = 4'b0100; set_div(2, 8);
    stepc("E_load8", 2, 1'b0, 1'b1);
    load = '0;
    run_sq("E_hold8", 2, 4, 1, 2, 1'b1);
    stepc("E_apply8", 2, 1'b1, 1'b0);
    load = 4'b0100; set_div(2, 4);
    stepc("E_load4", 2, 1'b0, 1'b1);
    load = '0;
    run_sq("E_hold4", 2, 8, 1, 6, 1'b1);
    load = 4'b0100; set_div(2, 6);
    stepc("E_both", 2, 1'b1, 1'b1);
    load = '0;
    run_sq("E_run4", 2, 4, 0, 3, 1'b1);
    stepc("E_apply6", 2, 1'b1, 1'b0);
    run_sq("E_sq6", 2, 6, 0, 6, 1'b0);

    // Divisors below 2 idle the channel
    load = 4'b0100; set_div(2, 1);
    stepc("F_load1", 2, 1'b0, 1'b1);
    load = '0;
    run_sq("F_hold", 2, 6, 1, 4, 1'b1);
    stepc("F_apply1", 2, 1'b1, 1'b0);
    repeat (4) stepc("F_idle", 2, 1'b0, 1'b0);
    load = 4'b1000; set_div(3, 0);
    stepc("F_load0", 3, 1'b0, 1'b1);
    load = '0;
    stepc("F_apply0", 3, 1'b0, 1'b0);
    en = 4'b1100;
    repeat (3) step("F_idle2", 4'b1100, '0, 4'b1100, '0, '0, '0);

    // Four independent channels 2/3/10/2, channel 2 in pulse mode
    en = '0;
    gdiv[0] = 2; gdiv[1] = 3; gdiv[2] = 10; gdiv[3] = 2;
    load = '1;
    for (int ch = 0; ch < NCH; ch++) set_div(ch, gdiv[ch]);
    step("G_load", '1, '0, '1, '1, '0, '0);
    load = '0;
    step("G_apply", '1, '0, '1, '0, '0, '0);
    en = '1; mode = 4'b0100;
    for (int s = 0; s < 32; s++) begin
      if (s == 30) begin
        load = 4'b0100; set_div(2, 7);
      end else begin
        load = '0;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        k = s % gdiv[ch];
        tv[ch] = (k == gdiv[ch] - 1);
        cv[ch] = mode[ch] ? tv[ch] : (k >= gdiv[ch] / 2);
      end
      bv = (s >= 30) ? 4'b0100 : 4'b0000;
      step("G_multi", '1, cv, '1, bv, '1, tv);
    end
    load = '0;

    // Reset mid-period with outputs high and a divisor pending
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("H_rst_clk", 32'(o_clk), 32'd0);
    check("H_rst_busy", 32'(o_busy), 32'd0);
`ifdef CLK_DIV_TICK_EN
    check("H_rst_tick", 32'(o_tick), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1; en = 4'b0101; mode = '0;
    for (int s = 0; s < 12; s++) begin
      k = s % RESET_DIV;
      cv = (k >= RESET_DIV / 2) ? 4'b0101 : 4'b0000;
      step("H_after", 4'b0101, cv, 4'b0101, '0, '0, '0);
    end

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Parametrised multi-channel programmable clock divider, the successor to the fixed-ratio dividers (/2, /10, /1M, /5M, /50M) driven from the 50 MHz board clock. Each channel has its own runtime divisor, output mode (square or single-cycle pulse) and enable. Divisor updates are double-buffered and take effect only at a period boundary, so outputs never glitch. Outputs drive LEDs, scan/refresh logic and slow state machines on the DE1 top level.

## Interface
- `NCH`, 4: number of independent channels.
- `WIDTH`, 26: divisor/counter width; 26 covers 50,000,000.
- `RESET_DIV`, 50000000: active divisor of every channel after reset.

- `clk`  in  1  system clock (CLOCK_50 at top level).
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_en`  in  NCH  per-channel run enable.
- `i_mode`  in  NCH  per-channel mode: 0 = square, 1 = pulse.
- `i_load`  in  NCH  per-channel load strobe; captures the divisor into the channel's pending register.
- `i_div`  in  NCH*WIDTH  divisors, flattened; channel k uses `i_div[k*WIDTH +: WIDTH]`.
- `o_clk`  out  NCH  divided outputs, registered.
- `o_busy`  out  NCH  pending divisor not yet applied.
- `o_tick`  out  NCH  period strobe; present only with `CLK_DIV_TICK_EN`.

## Operation
- Per-channel state: `cnt` (WIDTH), active divisor `D` (WIDTH), pending divisor `P` (WIDTH), pending flag `busy`.
- Reset: `cnt`=0, `D`=RESET_DIV, `P`=0, `busy`=0, `o_clk`=0, `o_tick`=0.
- Channel runs when `i_en`=1 and `D`>=2. In that state, `cnt` counts 0..D-1 and then wraps to 0.
- Channel idles when `i_en`=0 or `D`<2. While idle: `cnt` is held at 0, `o_clk`=0 and `o_tick`=0 on the next edge.
- Square mode: `o_clk` <= (`cnt` >= D/2), using integer division.
  - Low time is floor(D/2) cycles; high time is D-floor(D/2).
  - D=10 gives 5 low / 5 high. D=5 gives 2 low / 3 high.
- Pulse mode: `o_clk` <= (`cnt` == D-1). This is a one-cycle high pulse per period.
- `i_mode` is sampled every cycle. A mode change affects the very next `o_clk` value; the counter phase is unchanged.
- Load:
  - `i_load[k]`=1 at an edge sets P <= div_k and busy <= 1.
  - A second load while busy overwrites `P`; the last load wins.
- Apply: at an edge where busy=1 and either (running and `cnt`==D-1) or the channel is idle:
  - D <= P, cnt <= 0, busy <= 0.
- Simultaneous load and apply at the same edge:
  - The apply uses the `P` held before that edge.
  - The newly loaded value becomes the new `P`, and `busy` stays 1.
- Loading a divisor below 2 is legal. It is applied at the next boundary and the channel then idles.
- Reset asserted mid-period returns all state to the reset values immediately; the pending value is discarded.
- Channels are fully independent. There is no shared counter.

## Timing
- All outputs are registered. `o_clk` reflects the `cnt` value from the previous cycle (1-cycle latency).
- After `rst_n` deasserts with `i_en`=1 and square mode, `o_clk` first rises on edge D/2+1.
- Enable 0->1 edge: `cnt` starts from 0. `o_clk` follows the same 1-cycle lag.
- `o_busy` rises on the edge after `i_load` is sampled. It falls on the apply edge, at most D cycles later while running, or 1 cycle later while idle.
- The first period with the new divisor starts at `cnt`=0 on the apply edge. There are no truncated or stretched high phases.

## Configuration
- `CLK_DIV_TICK_EN` defined:
  - Adds port `o_tick`.
  - `o_tick[k]` <= running and (`cnt` == D-1), in both modes. This gives a one-cycle enable strobe per period, aligned with pulse-mode `o_clk`.
- `CLK_DIV_TICK_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then D=10 (load), square, en=1 → `o_clk` repeats 5 low / 5 high; `o_busy` clears within 1 cycle of load, because the channel is idle until en.
- D=5 square → 2 low / 3 high. Switch to pulse mode mid-run → a single-cycle pulse every 5 cycles, with no counter restart.
- Running D=8, load 4 at `cnt`=3 → `o_busy` high until the `cnt`=7 wrap, then a 2/2 period; no shortened high phase.
- Load 6 on the same edge as the `cnt`==D-1 wrap while P=4 pending → 4 is applied, 6 stays pending (`o_busy`=1) and is applied at the next wrap.
- Load D=1 or 0 → the channel idles at the next boundary with `o_clk`=0. Deassert `i_en` mid-period → `o_clk`=0 next edge, `cnt`=0. Assert `rst_n`=0 mid-period → all outputs 0 immediately, D=RESET_DIV.
- With `CLK_DIV_TICK_EN`: D=3, square → `o_tick` high 1 of every 3 cycles, coincident with the final high cycle of `o_clk`. With NCH=4, divisors 2/3/10/2 run independently.
